// File: rtl/branch_resolver_if.sv
// ----------------------------------------------------------------------------
// branch_resolver_if
// Purpose : bundles the ID-side decision inputs, the fetch redirect handshake
//           and the performance counter outputs of branch_resolver.
// Modports:
//   master : the ID/IF side. It drives the decode, compare and if_ready signals
//            and receives the redirect, hold, link and perf signals.
//   slave  : the resolver side (branch_resolver).
// Signals :
//   id_valid, id_stall, flush        ID qualifiers and the exception flush
//   br_type[3:0]                     decoded control-transfer type
//   equal, greater, less             comparator flags
//   id_pc[31:0], imm16[15:0]         branch PC and branch offset
//   instr_index[25:0], rs_data[31:0] jump index and forwarded rs
//   if_ready                         fetch accepts a redirect
//   redirect_valid, redirect_pc      redirect request to IF
//   id_hold                          freeze ID while a redirect is pending
//   link_en, link_pc                 jal/jalr link write
//   perf_branches/taken/hold         optional performance counters
// ----------------------------------------------------------------------------
interface branch_resolver_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             id_valid;
  logic             id_stall;
  logic             flush;
  logic [3:0]       br_type;
  logic             equal;
  logic             greater;
  logic             less;
  logic [31:0]      id_pc;
  logic [15:0]      imm16;
  logic [25:0]      instr_index;
  logic [31:0]      rs_data;
  logic             if_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             id_hold;
  logic             link_en;
  logic [31:0]      link_pc;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_taken;
  logic [CNT_W-1:0] perf_hold;

  modport master (
    output id_valid, id_stall, flush, br_type, equal, greater, less,
           id_pc, imm16, instr_index, rs_data, if_ready,
    input  redirect_valid, redirect_pc, id_hold, link_en, link_pc,
           perf_branches, perf_taken, perf_hold
  );

  modport slave (
    input  id_valid, id_stall, flush, br_type, equal, greater, less,
           id_pc, imm16, instr_index, rs_data, if_ready,
    output redirect_valid, redirect_pc, id_hold, link_en, link_pc,
           perf_branches, perf_taken, perf_hold
  );
endinterface

// File: rtl/branch_resolver.sv
// ----------------------------------------------------------------------------
// branch_resolver
// Purpose : resolves ID-stage branches and jumps from the comparator flags and
//           the decoded branch type. It computes the target and issues a PC
//           redirect to fetch. A redirect that fetch cannot take is held in
//           PENDING, and ID is frozen until fetch accepts it. The redirect
//           lands after the delay-slot fetch, so the delay-slot instruction
//           is never squashed here.
// Ports   :
//   clk    input   clock
//   reset  input   synchronous active-high reset
//   bus    slave   branch_resolver_if (decision inputs, redirect handshake,
//                  link write and perf counters)
// Config  : BR_PERF_EN enables the perf_branches/perf_taken/perf_hold
//           counters. When it is undefined the perf ports are tied to 0.
// ----------------------------------------------------------------------------
module branch_resolver #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  branch_resolver_if.slave bus
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned TYP_W = 4;

  localparam logic [TYP_W-1:0] BR_BEQ  = TYP_W'(1);
  localparam logic [TYP_W-1:0] BR_BNE  = TYP_W'(2);
  localparam logic [TYP_W-1:0] BR_BLEZ = TYP_W'(3);
  localparam logic [TYP_W-1:0] BR_BGTZ = TYP_W'(4);
  localparam logic [TYP_W-1:0] BR_BLTZ = TYP_W'(5);
  localparam logic [TYP_W-1:0] BR_BGEZ = TYP_W'(6);
  localparam logic [TYP_W-1:0] BR_J    = TYP_W'(7);
  localparam logic [TYP_W-1:0] BR_JAL  = TYP_W'(8);
  localparam logic [TYP_W-1:0] BR_JR   = TYP_W'(9);
  localparam logic [TYP_W-1:0] BR_JALR = TYP_W'(10);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pend_pc;

  logic              w_is_cf;
  logic              w_is_link;
  logic              w_cond_taken;
  logic              w_decision;
  logic              w_taken;
  logic [PC_W-1:0]   w_pc4;
  logic [PC_W-1:0]   w_br_off;
  logic [PC_W-1:0]   w_target;

  logic              w_redirect_valid;
  logic [PC_W-1:0]   w_redirect_pc;
  logic              w_id_hold;
  logic              w_link_en;
  logic              w_latch_pend;

  // Type classification and the taken condition for each control transfer.
  always_comb begin
    w_is_cf      = 1'b0;
    w_is_link    = 1'b0;
    w_cond_taken = 1'b0;
    unique case (bus.br_type)
      BR_BEQ:  begin w_is_cf = 1'b1; w_cond_taken =  bus.equal;   end
      BR_BNE:  begin w_is_cf = 1'b1; w_cond_taken = !bus.equal;   end
      BR_BLEZ: begin w_is_cf = 1'b1; w_cond_taken = !bus.greater; end
      BR_BGTZ: begin w_is_cf = 1'b1; w_cond_taken =  bus.greater; end
      BR_BLTZ: begin w_is_cf = 1'b1; w_cond_taken =  bus.less;    end
      BR_BGEZ: begin w_is_cf = 1'b1; w_cond_taken = !bus.less;    end
      BR_J:    begin w_is_cf = 1'b1; w_cond_taken = 1'b1;         end
      BR_JAL:  begin w_is_cf = 1'b1; w_cond_taken = 1'b1; w_is_link = 1'b1; end
      BR_JR:   begin w_is_cf = 1'b1; w_cond_taken = 1'b1;         end
      BR_JALR: begin w_is_cf = 1'b1; w_cond_taken = 1'b1; w_is_link = 1'b1; end
      default: begin w_is_cf = 1'b0; w_cond_taken = 1'b0;         end
    endcase
  end

  // A decision is only taken in IDLE with ready operands. Reset also blocks
  // it, so the outputs stay quiet and nothing is counted during reset.
  assign w_decision = bus.id_valid && !bus.id_stall && !bus.flush && !reset &&
                      w_is_cf && (r_state == S_IDLE);
  assign w_taken    = w_decision && w_cond_taken;

  // Targets use modulo-2^32 arithmetic, so id_pc near the top wraps to 0.
  assign w_pc4    = bus.id_pc + PC_W'(4);
  assign w_br_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

  always_comb begin
    w_target = w_pc4 + w_br_off;
    unique case (bus.br_type)
      BR_J, BR_JAL:   w_target = {w_pc4[31:28], bus.instr_index, 2'b00};
      BR_JR, BR_JALR: w_target = bus.rs_data;
      default:        w_target = w_pc4 + w_br_off;
    endcase
  end

  // Redirect FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and redirect/hold/link outputs. Priority is reset, then
  // flush, then the normal handshake.
  always_comb begin
    w_state_nxt      = r_state;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_id_hold        = 1'b0;
    w_link_en        = 1'b0;
    w_latch_pend     = 1'b0;
    if (reset) begin
      w_state_nxt = S_IDLE;
    end else if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_id_hold   = (r_state == S_PENDING);
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_link_en = w_decision && w_is_link;
          if (w_taken) begin
            w_redirect_valid = 1'b1;
            w_redirect_pc    = w_target;
            if (!bus.if_ready) begin
              w_id_hold    = 1'b1;
              w_latch_pend = 1'b1;
              w_state_nxt  = S_PENDING;
            end
          end
        end
        S_PENDING: begin
          w_redirect_valid = 1'b1;
          w_redirect_pc    = r_pend_pc;
          w_id_hold        = 1'b1;
          if (bus.if_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Target held across fetch back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_pc <= '0;
    end else if (w_latch_pend) begin
      r_pend_pc <= w_target;
    end
  end

  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.id_hold        = w_id_hold;
  assign bus.link_en        = w_link_en;
  assign bus.link_pc        = bus.id_pc + PC_W'(8);

`ifdef BR_PERF_EN
  logic [CNT_W-1:0] r_perf_branches;
  logic [CNT_W-1:0] r_perf_taken;
  logic [CNT_W-1:0] r_perf_hold;

  // Free-running wrap-around counters. Flush does not clear them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_branches <= '0;
      r_perf_taken    <= '0;
      r_perf_hold     <= '0;
    end else begin
      if (w_decision) begin
        r_perf_branches <= r_perf_branches + CNT_W'(1);
      end
      if (w_taken) begin
        r_perf_taken <= r_perf_taken + CNT_W'(1);
      end
      if (r_state == S_PENDING) begin
        r_perf_hold <= r_perf_hold + CNT_W'(1);
      end
    end
  end

  assign bus.perf_branches = r_perf_branches;
  assign bus.perf_taken    = r_perf_taken;
  assign bus.perf_hold     = r_perf_hold;
`else
  assign bus.perf_branches = '0;
  assign bus.perf_taken    = '0;
  assign bus.perf_hold     = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// ----------------------------------------------------------------------------
// tb_branch_resolver
// Purpose : directed self-checking bench for branch_resolver. Inputs change
//           1 time unit after the rising edge. Outputs are sampled on the
//           falling edge.
// ----------------------------------------------------------------------------
module tb_branch_resolver;

  localparam int unsigned CNT_W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  branch_resolver_if #(.CNT_W(CNT_W)) br_if ();

  branch_resolver #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (br_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Expected perf value. It is 0 when the counters are compiled out.
  function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef BR_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    br_if.id_valid    = 1'b0;
    br_if.id_stall    = 1'b0;
    br_if.flush       = 1'b0;
    br_if.br_type     = 4'd0;
    br_if.equal       = 1'b0;
    br_if.greater     = 1'b0;
    br_if.less        = 1'b0;
    br_if.id_pc       = 32'd0;
    br_if.imm16       = 16'd0;
    br_if.instr_index = 26'd0;
    br_if.rs_data     = 32'd0;
    br_if.if_ready    = 1'b1;
  endtask

  task automatic issue(input logic [3:0] typ, input logic [31:0] pc, input logic [15:0] imm,
                       input logic eq, input logic gt, input logic lt, input logic rdy);
    br_if.id_valid = 1'b1;
    br_if.br_type  = typ;
    br_if.id_pc    = pc;
    br_if.imm16    = imm;
    br_if.equal    = eq;
    br_if.greater  = gt;
    br_if.less     = lt;
    br_if.if_ready = rdy;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    reset = 1'b1;

    // Reset with a jal presented: outputs must stay quiet.
    issue(4'd8, 32'h0000_3008, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    br_if.instr_index = 26'h0000C10;
    smp();
    check("rst_rv", 32'(br_if.redirect_valid), 32'd0);
    check("rst_hold", 32'(br_if.id_hold), 32'd0);
    check("rst_link", 32'(br_if.link_en), 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    idle_inputs();
    smp();
    check("rst_perf_br", br_if.perf_branches, 32'd0);
    check("idle_rv", 32'(br_if.redirect_valid), 32'd0);
    cyc();

    // beq taken
    issue(4'd1, 32'h0000_3000, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b1);
    smp();
    check("beq_rv", 32'(br_if.redirect_valid), 32'd1);
    check("beq_pc", br_if.redirect_pc, 32'h0000_3014);
    check("beq_hold", 32'(br_if.id_hold), 32'd0);
    check("beq_link", 32'(br_if.link_en), 32'd0);
    cyc();

    // bne with equal set: not taken
    issue(4'd2, 32'h0000_3000, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b1);
    smp();
    check("bne_rv", 32'(br_if.redirect_valid), 32'd0);
    cyc();

    // bgtz with greater clear: not taken
    issue(4'd4, 32'h0000_3000, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1);
    smp();
    check("bgtz_rv", 32'(br_if.redirect_valid), 32'd0);
    cyc();

    // bgez with less clear: taken
    issue(4'd6, 32'h0000_3000, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1);
    smp();
    check("bgez_rv", 32'(br_if.redirect_valid), 32'd1);
    check("bgez_pc", br_if.redirect_pc, 32'h0000_3014);
    cyc();

    // backward branch
    issue(4'd1, 32'h0000_3010, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    smp();
    check("back_pc", br_if.redirect_pc, 32'h0000_3010);
    cyc();

    // address wrap
    issue(4'd1, 32'hFFFF_FFFC, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    smp();
    check("wrap_rv", 32'(br_if.redirect_valid), 32'd1);
    check("wrap_pc", br_if.redirect_pc, 32'h0000_0000);
    cyc();

    // jal with fetch busy for 3 cycles
    issue(4'd8, 32'h0000_3008, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    br_if.instr_index = 26'h0000C10;
    smp();
    check("jal_link", 32'(br_if.link_en), 32'd1);
    check("jal_lpc", br_if.link_pc, 32'h0000_3010);
    check("jal_rv", 32'(br_if.redirect_valid), 32'd1);
    check("jal_pc", br_if.redirect_pc, 32'h0000_3040);
    check("jal_hold", 32'(br_if.id_hold), 32'd1);
    cyc();
    // A new branch presented during PENDING must be ignored.
    issue(4'd1, 32'h0000_0100, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      smp();
      check("pend_rv", 32'(br_if.redirect_valid), 32'd1);
      check("pend_pc", br_if.redirect_pc, 32'h0000_3040);
      check("pend_hold", 32'(br_if.id_hold), 32'd1);
      check("pend_link", 32'(br_if.link_en), 32'd0);
      cyc();
    end
    br_if.if_ready = 1'b1;
    smp();
    check("acc_rv", 32'(br_if.redirect_valid), 32'd1);
    check("acc_pc", br_if.redirect_pc, 32'h0000_3040);
    cyc();
    idle_inputs();
    br_if.if_ready = 1'b0;
    smp();
    check("post_rv", 32'(br_if.redirect_valid), 32'd0);
    check("post_hold", 32'(br_if.id_hold), 32'd0);
    check("perf_hold3", br_if.perf_hold, pexp(32'd3));
    check("perf_br7", br_if.perf_branches, pexp(32'd7));
    check("perf_tk5", br_if.perf_taken, pexp(32'd5));
    cyc();

    // jr while stalled for 2 cycles
    issue(4'd9, 32'h0000_2000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    br_if.rs_data  = 32'h0040_0000;
    br_if.id_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      smp();
      check("stall_rv", 32'(br_if.redirect_valid), 32'd0);
      cyc();
    end
    br_if.id_stall = 1'b0;
    smp();
    check("jr_rv", 32'(br_if.redirect_valid), 32'd1);
    check("jr_pc", br_if.redirect_pc, 32'h0040_0000);
    check("jr_link", 32'(br_if.link_en), 32'd0);
    cyc();

    // jalr: links and jumps to rs
    br_if.br_type = 4'd10;
    br_if.rs_data = 32'h1234_5678;
    smp();
    check("jalr_pc", br_if.redirect_pc, 32'h1234_5678);
    check("jalr_link", 32'(br_if.link_en), 32'd1);
    check("jalr_lpc", br_if.link_pc, 32'h0000_2008);
    cyc();

    // reserved type acts as none
    br_if.br_type = 4'd12;
    smp();
    check("rsvd_rv", 32'(br_if.redirect_valid), 32'd0);
    check("rsvd_link", 32'(br_if.link_en), 32'd0);
    cyc();

    // flush cancels a decision in the same cycle
    issue(4'd8, 32'h0000_3008, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    br_if.flush = 1'b1;
    smp();
    check("flidle_rv", 32'(br_if.redirect_valid), 32'd0);
    check("flidle_link", 32'(br_if.link_en), 32'd0);
    cyc();
    br_if.flush = 1'b0;

    // PENDING, then flush
    issue(4'd1, 32'h0000_3000, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0);
    smp();
    check("flpend_hold", 32'(br_if.id_hold), 32'd1);
    cyc();
    idle_inputs();
    br_if.if_ready = 1'b0;
    br_if.flush    = 1'b1;
    smp();
    check("flush_rv", 32'(br_if.redirect_valid), 32'd0);
    cyc();
    br_if.flush = 1'b0;
    smp();
    check("flush_idle_rv", 32'(br_if.redirect_valid), 32'd0);
    check("flush_idle_hold", 32'(br_if.id_hold), 32'd0);
    check("perf_br10", br_if.perf_branches, pexp(32'd10));
    check("perf_tk8", br_if.perf_taken, pexp(32'd8));
    check("perf_hold4", br_if.perf_hold, pexp(32'd4));
    cyc();

    // reset mid-PENDING
    issue(4'd8, 32'h0000_3008, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    br_if.instr_index = 26'h0000C10;
    cyc();
    idle_inputs();
    br_if.if_ready = 1'b0;
    reset = 1'b1;
    smp();
    check("rstp_rv", 32'(br_if.redirect_valid), 32'd0);
    check("rstp_hold", 32'(br_if.id_hold), 32'd0);
    check("rstp_link", 32'(br_if.link_en), 32'd0);
    cyc();
    reset = 1'b0;
    smp();
    check("rstp_idle_rv", 32'(br_if.redirect_valid), 32'd0);
    check("rstp_idle_hold", 32'(br_if.id_hold), 32'd0);
    check("rstp_perf_br", br_if.perf_branches, 32'd0);
    check("rstp_perf_tk", br_if.perf_taken, 32'd0);
    check("rstp_perf_hold", br_if.perf_hold, 32'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer end of the ID-stage compare path: takes the equal/greater/less flags from the ID-stage comparator together with the decoded branch type.
- Decides branch/jump outcome, computes the target, and issues a PC redirect to the fetch stage.
- Holds the redirect across fetch back-pressure and stalls ID while a redirect is pending.
- Sits between ID decode/compare and the IF PC register; supports the MIPS delay slot (redirect applies after the delay-slot fetch).

Parameters:
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- id_valid  input  1  ID holds a valid instruction
- id_stall  input  1  hazard unit: ID operands not ready, decision must not be taken
- flush  input  1  exception/eret flush; discards the current decision and any pending redirect
- br_type  input  4  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 j, 8 jal, 9 jr, 10 jalr; 11-15 treated as none
- equal  input  1  rs==rt (from comparator)
- greater  input  1  signed rs>0
- less  input  1  signed rs<0
- id_pc  input  32  PC of the branch in ID
- imm16  input  16  branch offset
- instr_index  input  26  j/jal index field
- rs_data  input  32  forwarded rs, used by jr/jalr
- if_ready  input  1  fetch accepts a redirect this cycle
- redirect_valid  output  1  redirect request to IF
- redirect_pc  output  32  target PC
- id_hold  output  1  freeze ID/IF-ID while a redirect is pending
- link_en  output  1  jal/jalr write link this cycle
- link_pc  output  32  id_pc+8
- perf_branches  output  CNT_W  resolved control-transfer count (optional)
- perf_taken  output  CNT_W  taken count (optional)
- perf_hold  output  CNT_W  cycles spent in PENDING (optional)

Behaviour:
- Decision (combinational) fires when id_valid && !id_stall && !flush && type!=none && state==IDLE.
- Taken conditions:
  - beq = equal; bne = !equal
  - blez = !greater; bgtz = greater
  - bltz = less; bgez = !less
  - types 7-10 always taken
- Targets, 32-bit modulo arithmetic:
  - branch: id_pc+4+(sign_ext(imm16)<<2)
  - j/jal: {pc4[31:28], instr_index, 2'b00}, with pc4 = id_pc+4
  - jr/jalr: rs_data
- link_en = decision && type in {jal, jalr}; link_pc = id_pc+8. Both combinational; link_en is 0 when no decision fires.
- FSM states IDLE, PENDING:
  - IDLE: redirect_valid = decision && taken; redirect_pc = computed target.
    - If redirect_valid && if_ready: accepted same cycle, stay IDLE.
    - If redirect_valid && !if_ready: latch target into pend_pc, go to PENDING.
  - PENDING: redirect_valid=1, redirect_pc=pend_pc, id_hold=1; new decisions suppressed.
    - if_ready → IDLE next cycle.
    - flush → IDLE, pending dropped.
- id_hold = (state==PENDING) || (IDLE && redirect_valid && !if_ready).
- Not-taken branch: redirect_valid=0, no state change.
- flush has priority over everything: redirect_valid=0, link_en=0 the same cycle, state→IDLE.
- Latency: redirect zero-cycle from decision; pending redirect held until the accepting edge.
- Reset (sync): state=IDLE, pend_pc=0, counters=0. redirect_valid/id_hold/link_en are 0 during reset cycles regardless of inputs.
- Reset during PENDING: pending redirect discarded.

Optional Feature:
- BR_PERF_EN defined:
  - perf_branches +1 per decision.
  - perf_taken +1 per taken decision.
  - perf_hold +1 per cycle in PENDING.
  - Counters wrap at 2^CNT_W; cleared by reset, not by flush.
- BR_PERF_EN undefined: the perf_* ports exist but are tied to 0; no counter registers.

Test Plan:
- beq, equal=1, id_pc=0x00003000, imm16=0x0004, if_ready=1 → redirect_valid=1, redirect_pc=0x00003014, id_hold=0.
- bne, equal=1 → redirect_valid=0; bgtz with greater=0 → 0; bgez with less=0 → redirect_valid=1.
- Backward branch: imm16=0xFFFF, id_pc=0x00003010 → redirect_pc=0x00003010. Overflow case: id_pc=0xFFFFFFFC, imm16=0 → redirect_pc=0x00000000.
- jal, id_pc=0x00003008, instr_index=0x0000C10, if_ready=0 for 3 cycles:
  - decision cycle: link_en=1, link_pc=0x00003010.
  - redirect_pc=0x00003040 held with id_hold=1 through PENDING, IDLE after the if_ready edge.
  - with BR_PERF_EN: perf_hold=3.
- jr, rs_data=0x00400000, id_stall=1 for 2 cycles → no redirect while stalled; redirect_valid=1, redirect_pc=0x00400000 in the first cycle id_stall=0.
- PENDING then flush=1 → redirect_valid=0 that cycle, IDLE next. Separately, reset asserted mid-PENDING → all outputs 0 and counters cleared.
